// File: rtl/multi_watchdog.sv
// N-channel watchdog: shared prescaler, per-channel timeout/window registers,
// early-kick detection and two-stage escalation to a sticky system reset request.
module multi_watchdog #(
  parameter  int NUM_CH = 3,
  parameter  int CNT_W  = 16,
  parameter  int PRE_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PRE_W-1:0]  prescale,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] kick,
  input  logic [NUM_CH-1:0] clr,
  input  logic [NUM_CH-1:0] win_mode,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] early,
  output logic              irq,
  output logic              sys_rst_req
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXP  = 2'd2
  } ch_state_e;

  ch_state_e          state_r   [NUM_CH];
  logic [CNT_W-1:0]   cnt_r     [NUM_CH];
  logic [CNT_W-1:0]   timeout_r [NUM_CH];
  logic [CNT_W-1:0]   window_r  [NUM_CH];
  logic [NUM_CH-1:0]  expired_r;
  logic [NUM_CH-1:0]  early_r;
  logic               sys_rst_req_r;
  logic [PRE_W-1:0]   pc_r;
  logic               tick_s;

  // Equality compare lets a new prescale take effect mid-count; pc wraps if it overshoots.
  assign tick_s = (pc_r == prescale);

  // Free-running prescaler counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= '0;
    end else if (tick_s) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_r + PRE_W'(1);
    end
  end

  // Timeout/window register file; out-of-range channel writes match no entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        timeout_r[i] <= '1;
        window_r[i]  <= '1;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          if (cfg_sel) begin
            window_r[i] <= cfg_data;
          end else begin
            timeout_r[i] <= cfg_data;
          end
        end
      end
    end
  end

  // Per-channel watchdog FSMs and the shared escalation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= '0;
      end
      expired_r     <= '0;
      early_r       <= '0;
      sys_rst_req_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_en[i]) begin
          state_r[i]   <= ST_IDLE;
          cnt_r[i]     <= '0;
          expired_r[i] <= 1'b0;
          early_r[i]   <= 1'b0;
        end else begin
          case (state_r[i])
            ST_IDLE: begin
              state_r[i] <= ST_RUN;
              cnt_r[i]   <= timeout_r[i];
            end
            ST_RUN: begin
              if (kick[i]) begin
                cnt_r[i] <= timeout_r[i];
                if (win_mode[i] && (cnt_r[i] > window_r[i])) begin
                  early_r[i] <= 1'b1;
                  state_r[i] <= ST_EXP;
                end
              end else if (tick_s) begin
                if (cnt_r[i] == '0) begin
                  expired_r[i] <= 1'b1;
                  state_r[i]   <= ST_EXP;
                  cnt_r[i]     <= timeout_r[i];
                end else begin
                  cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end
              end
            end
            ST_EXP: begin
              // Second stage: a re-arm wins over the escalation tick.
              if (clr[i]) begin
                expired_r[i] <= 1'b0;
                early_r[i]   <= 1'b0;
                state_r[i]   <= ST_RUN;
                cnt_r[i]     <= timeout_r[i];
              end else if (tick_s) begin
                if (cnt_r[i] == '0) begin
                  sys_rst_req_r <= 1'b1;
                end else begin
                  cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end
              end
            end
            default: begin
              state_r[i] <= ST_IDLE;
              cnt_r[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign expired     = expired_r;
  assign early       = early_r;
  assign irq         = |{expired_r, early_r};
  assign sys_rst_req = sys_rst_req_r;

endmodule

// File: doc/multi_watchdog.md
# multi_watchdog

Parametrised N-channel watchdog timer with a shared prescaler, per-channel programmable timeout, optional window mode (early-kick detection) and a two-stage escalation to a sticky system reset request. It is the next-generation core behind the team's TinyTapeout watchdog top-level. The tt_um wrapper maps `ui_in`/`uio_in` onto kicks, enables and the config bus, and maps flags onto `uo_out`.

## Interface
Parameters:
- `NUM_CH`, default 3: number of independent channels (1..8).
- `CNT_W`, default 16: width of timeout, window and counter registers.
- `PRE_W`, default 8: prescaler width.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `prescale`, input, PRE_W: a tick occurs every `prescale+1` clocks.
- `ch_en`, input, NUM_CH: per-channel enable, level.
- `kick`, input, NUM_CH: per-channel kick, sampled every cycle. Each high cycle counts as one kick.
- `clr`, input, NUM_CH: per-channel flag clear / re-arm, sampled every cycle.
- `win_mode`, input, NUM_CH: per-channel window-mode select.
- `cfg_we`, input, 1: configuration write strobe.
- `cfg_ch`, input, clog2(NUM_CH) (min 1): target channel.
- `cfg_sel`, input, 1: 0 = timeout register, 1 = window register.
- `cfg_data`, input, CNT_W: write data.
- `expired`, output, NUM_CH: sticky timeout flag.
- `early`, output, NUM_CH: sticky early-kick flag.
- `irq`, output, 1: OR of all `expired` and `early` bits (combinational from registered flags).
- `sys_rst_req`, output, 1: sticky second-stage escalation; cleared only by `rst`.

## Operation
- **Prescaler:** free-running counter `pc`.
  - `tick`=1 in a cycle where `pc==prescale`; `pc` returns to 0 on the next clock, else increments.
  - `prescale=0` gives a tick every cycle.
  - A `prescale` change mid-count takes effect by comparison. If `pc>prescale`, `pc` wraps at 2^PRE_W.
- **Config:** on `cfg_we`, write `timeout[cfg_ch]` or `window[cfg_ch]`.
  - `cfg_ch>=NUM_CH`: write ignored.
  - Writes never alter a running counter; they apply at the next reload.
- **Per-channel FSM** (IDLE, RUN, EXPIRED), with `cnt[i]`:
  - IDLE: `cnt=0`, flags 0. If `ch_en[i]`, go to RUN next cycle with `cnt=timeout[i]`.
  - RUN, kick with `win_mode[i]` and `cnt>window[i]`: `early[i]=1`, go to EXPIRED, `cnt=timeout[i]`.
  - RUN, any other kick: `cnt=timeout[i]`. A kick beats a tick in the same cycle.
  - RUN, tick with `cnt==0`: `expired[i]=1`, go to EXPIRED, `cnt=timeout[i]` (stage 2 starts).
  - RUN, tick with `cnt!=0`: `cnt` decrements.
  - EXPIRED: kicks ignored. A tick decrements `cnt`. A tick with `cnt==0` sets `sys_rst_req=1` and `cnt` holds at 0.
  - `clr[i]` in EXPIRED: clears `expired[i]`/`early[i]` and returns to RUN with `cnt=timeout[i]`. `clr` in IDLE/RUN has no effect.
  - `ch_en[i]=0` in any state: go to IDLE next cycle, clearing `cnt` and flags. This takes priority over `clr`, kick and tick. `sys_rst_req` is unaffected.
- **Timeout register:** `timeout=0` expires on the first tick after load.
- **Arithmetic:** unsigned. `cnt` never underflows.

## Timing
- **Reset values:**
  - `expired`, `early`, `irq`, `sys_rst_req`: 0.
  - All FSMs: IDLE. `cnt`: 0. `pc`: 0.
  - `timeout[*]` and `window[*]`: all-ones, so window mode never flags early by default.
- **Enable:** `ch_en` sampled high in cycle t gives RUN with `cnt=timeout` at t+1. No decrement occurs in cycle t.
- **Flag latency:** flags rise one clock after the deciding tick or kick. `irq` follows in the same cycle as the flag.
- **Expiry time:** with a tick every cycle, `expired` rises `timeout+2` cycles after `ch_en` is first sampled high.
- **Mid-operation reset:** `rst` asserted at any point returns everything to reset values on the next edge, including mid-count and a pending `sys_rst_req`.
- **Simultaneous events:** all channels evaluate independently in the same cycle. Multiple channels may escalate together; `sys_rst_req` is simply set.

## Test plan
- **Basic expiry:** `prescale=0`, `timeout[0]=5`, `ch_en=3'b001` at cycle 0, no kicks → `expired[0]` and `irq` rise at cycle 7; `early` stays 0.
- **Periodic kick:** same setup, kick ch0 every 4 cycles for 100 cycles → `expired` stays 0. Kick and tick coincide each time; `cnt` reloads to 5.
- **Window mode:** `timeout[1]=10`, `window[1]=3`, `win_mode[1]=1`, kick ch1 when `cnt=7` → `early[1]=1` and `expired[1]=0` the next cycle. A kick at `cnt=3` reloads with no flag.
- **Escalation:** ch2 `timeout=4` expires, no `clr` → `sys_rst_req=1` 5 cycles after `expired[2]` rises. `ch_en=0` leaves it set; `rst` clears it.
- **Prescaler and config:** `prescale=3`, `timeout[0]=2` → `expired[0]` rises 12 cycles (±3 phase) after enable. Rewrite the timeout mid-count → no effect until the next kick. Write with `cfg_ch=3` → no register changes.
- **Clear and disable:** `clr[0]` in EXPIRED → flags drop the next cycle and the count restarts from `timeout`. `clr` with `ch_en` low in the same cycle → IDLE, `cnt=0`.
